// File: rtl/alu_exec.sv
// alu_exec: integer execute stage downstream of the reservation station.
//
// Takes one dispatched micro-op per cycle and computes:
//   - the ALU result,
//   - the branch/jump outcome,
//   - the redirect target.
// The result is queued in a small result FIFO. The FIFO head is presented to the CDB and popped
// under a request/grant handshake.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   rdy             global enable; low freezes all state
//   jump_rst        synchronous misprediction flush (empties the FIFO)
//   RS_send_ALU     dispatch valid; ALU_op / ALU_Vj / ALU_Vk / ALU_imm / ALU_curPC / ALU_reorder
//   alu_stall       RS must not dispatch on the next edge
//   cdb_req         FIFO head valid
//   cdb_value       head result
//   cdb_reorder     head ROB tag
//   cdb_jump        head redirect flag
//   cdb_target      head redirect target
//   cdb_grant       CDB accepts the head this edge
//   alu_overflow    sticky: a result was dropped because the FIFO was full
//
// Op encoding (shared with the rest of the core):
//   0                unknown
//   1 .. 4           LUI, AUIPC, JAL, JALR
//   5 .. 10          BEQ, BNE, BLT, BGE, BLTU, BGEU
//   11 .. 19         ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI
//   20 .. 29         ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND
//   30, 31           unknown
module alu_exec #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned FIFO_DEPTH_LOG = 2,
  parameter int unsigned OP_SIZE_LOG    = 5,
  parameter int unsigned ROB_SIZE_LOG   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    jump_rst,
  input  logic                    RS_send_ALU,
  input  logic [OP_SIZE_LOG-1:0]  ALU_op,
  input  logic [31:0]             ALU_Vj,
  input  logic [31:0]             ALU_Vk,
  input  logic [31:0]             ALU_imm,
  input  logic [31:0]             ALU_curPC,
  input  logic [ROB_SIZE_LOG-1:0] ALU_reorder,
  output logic                    alu_stall,
  output logic                    cdb_req,
  output logic [31:0]             cdb_value,
  output logic [ROB_SIZE_LOG-1:0] cdb_reorder,
  output logic                    cdb_jump,
  output logic [31:0]             cdb_target,
  input  logic                    cdb_grant,
  output logic                    alu_overflow
);

  localparam logic [OP_SIZE_LOG-1:0] OP_LUI   = OP_SIZE_LOG'(1);
  localparam logic [OP_SIZE_LOG-1:0] OP_AUIPC = OP_SIZE_LOG'(2);
  localparam logic [OP_SIZE_LOG-1:0] OP_JAL   = OP_SIZE_LOG'(3);
  localparam logic [OP_SIZE_LOG-1:0] OP_JALR  = OP_SIZE_LOG'(4);
  localparam logic [OP_SIZE_LOG-1:0] OP_BEQ   = OP_SIZE_LOG'(5);
  localparam logic [OP_SIZE_LOG-1:0] OP_BNE   = OP_SIZE_LOG'(6);
  localparam logic [OP_SIZE_LOG-1:0] OP_BLT   = OP_SIZE_LOG'(7);
  localparam logic [OP_SIZE_LOG-1:0] OP_BGE   = OP_SIZE_LOG'(8);
  localparam logic [OP_SIZE_LOG-1:0] OP_BLTU  = OP_SIZE_LOG'(9);
  localparam logic [OP_SIZE_LOG-1:0] OP_BGEU  = OP_SIZE_LOG'(10);
  localparam logic [OP_SIZE_LOG-1:0] OP_ADDI  = OP_SIZE_LOG'(11);
  localparam logic [OP_SIZE_LOG-1:0] OP_SLTI  = OP_SIZE_LOG'(12);
  localparam logic [OP_SIZE_LOG-1:0] OP_SLTIU = OP_SIZE_LOG'(13);
  localparam logic [OP_SIZE_LOG-1:0] OP_XORI  = OP_SIZE_LOG'(14);
  localparam logic [OP_SIZE_LOG-1:0] OP_ORI   = OP_SIZE_LOG'(15);
  localparam logic [OP_SIZE_LOG-1:0] OP_ANDI  = OP_SIZE_LOG'(16);
  localparam logic [OP_SIZE_LOG-1:0] OP_SLLI  = OP_SIZE_LOG'(17);
  localparam logic [OP_SIZE_LOG-1:0] OP_SRLI  = OP_SIZE_LOG'(18);
  localparam logic [OP_SIZE_LOG-1:0] OP_SRAI  = OP_SIZE_LOG'(19);
  localparam logic [OP_SIZE_LOG-1:0] OP_ADD   = OP_SIZE_LOG'(20);
  localparam logic [OP_SIZE_LOG-1:0] OP_SUB   = OP_SIZE_LOG'(21);
  localparam logic [OP_SIZE_LOG-1:0] OP_SLL   = OP_SIZE_LOG'(22);
  localparam logic [OP_SIZE_LOG-1:0] OP_SLT   = OP_SIZE_LOG'(23);
  localparam logic [OP_SIZE_LOG-1:0] OP_SLTU  = OP_SIZE_LOG'(24);
  localparam logic [OP_SIZE_LOG-1:0] OP_XOR   = OP_SIZE_LOG'(25);
  localparam logic [OP_SIZE_LOG-1:0] OP_SRL   = OP_SIZE_LOG'(26);
  localparam logic [OP_SIZE_LOG-1:0] OP_SRA   = OP_SIZE_LOG'(27);
  localparam logic [OP_SIZE_LOG-1:0] OP_OR    = OP_SIZE_LOG'(28);
  localparam logic [OP_SIZE_LOG-1:0] OP_AND   = OP_SIZE_LOG'(29);

  localparam int unsigned CntW = FIFO_DEPTH_LOG + 1;
  localparam logic [CntW-1:0] CntFull  = CntW'(FIFO_DEPTH);
  localparam logic [CntW-1:0] CntStall = CntW'(FIFO_DEPTH - 2);

  // ---------------------------------------------------------------------------------------------
  // Execute
  // ---------------------------------------------------------------------------------------------
  logic        is_itype;
  logic        is_branch;
  logic        taken;
  logic [31:0] opb;
  logic [4:0]  shamt;
  logic [31:0] pc_plus4;
  logic [31:0] pc_plus_imm;
  logic [31:0] jalr_sum;
  logic [31:0] res_value;
  logic        res_jump;
  logic [31:0] res_target;

  always_comb begin
    is_itype    = (ALU_op >= OP_ADDI) && (ALU_op <= OP_SRAI);
    opb         = is_itype ? ALU_imm : ALU_Vk;
    shamt       = opb[4:0];
    pc_plus4    = ALU_curPC + 32'd4;
    pc_plus_imm = ALU_curPC + ALU_imm;
    jalr_sum    = ALU_Vj + ALU_imm;
    is_branch   = 1'b0;
    taken       = 1'b0;
    res_value   = '0;
    res_jump    = 1'b0;
    res_target  = '0;

    case (ALU_op)
      OP_ADD, OP_ADDI:   res_value = ALU_Vj + opb;
      OP_SUB:            res_value = ALU_Vj - ALU_Vk;
      OP_SLL, OP_SLLI:   res_value = ALU_Vj << shamt;
      OP_SLT, OP_SLTI:   res_value = {31'b0, $signed(ALU_Vj) < $signed(opb)};
      OP_SLTU, OP_SLTIU: res_value = {31'b0, ALU_Vj < opb};
      OP_XOR, OP_XORI:   res_value = ALU_Vj ^ opb;
      OP_OR, OP_ORI:     res_value = ALU_Vj | opb;
      OP_AND, OP_ANDI:   res_value = ALU_Vj & opb;
      OP_SRL, OP_SRLI:   res_value = ALU_Vj >> shamt;
      OP_SRA, OP_SRAI:   res_value = 32'($signed(ALU_Vj) >>> shamt);
      OP_LUI:            res_value = ALU_imm;
      OP_AUIPC:          res_value = pc_plus_imm;
      OP_JAL: begin
        res_value  = pc_plus4;
        res_jump   = 1'b1;
        res_target = pc_plus_imm;
      end
      OP_JALR: begin
        res_value  = pc_plus4;
        res_jump   = 1'b1;
        res_target = jalr_sum & ~32'd1;
      end
      OP_BEQ: begin
        is_branch = 1'b1;
        taken     = (ALU_Vj == ALU_Vk);
      end
      OP_BNE: begin
        is_branch = 1'b1;
        taken     = (ALU_Vj != ALU_Vk);
      end
      OP_BLT: begin
        is_branch = 1'b1;
        taken     = $signed(ALU_Vj) < $signed(ALU_Vk);
      end
      OP_BGE: begin
        is_branch = 1'b1;
        taken     = $signed(ALU_Vj) >= $signed(ALU_Vk);
      end
      OP_BLTU: begin
        is_branch = 1'b1;
        taken     = ALU_Vj < ALU_Vk;
      end
      OP_BGEU: begin
        is_branch = 1'b1;
        taken     = ALU_Vj >= ALU_Vk;
      end
      default: ;
    endcase

    // Branches always carry a target so the ROB can redirect on either outcome.
    if (is_branch) begin
      res_jump   = taken;
      res_target = taken ? pc_plus_imm : pc_plus4;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Result FIFO
  // ---------------------------------------------------------------------------------------------
  logic [31:0]             value_q   [FIFO_DEPTH];
  logic [ROB_SIZE_LOG-1:0] reorder_q [FIFO_DEPTH];
  logic                    jump_q    [FIFO_DEPTH];
  logic [31:0]             target_q  [FIFO_DEPTH];

  logic [FIFO_DEPTH_LOG-1:0] head_q, head_d;
  logic [FIFO_DEPTH_LOG-1:0] tail_q, tail_d;
  logic [CntW-1:0]           count_q, count_d;
  logic                      overflow_q, overflow_d;

  logic active;
  logic full;
  logic push;
  logic pop;
  logic drop;

  always_comb begin
    active = rdy && !jump_rst;
    full   = (count_q == CntFull);
    pop    = active && cdb_req && cdb_grant;
    // A full FIFO still accepts when the head leaves on the same edge.
    push   = active && RS_send_ALU && (!full || pop);
    drop   = active && RS_send_ALU && full && !pop;

    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop;

    if (jump_rst) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + FIFO_DEPTH_LOG'(1);
      if (pop)  head_d = head_q + FIFO_DEPTH_LOG'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        value_q[i]   <= '0;
        reorder_q[i] <= '0;
        jump_q[i]    <= 1'b0;
        target_q[i]  <= '0;
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      if (push) begin
        value_q[tail_q]   <= res_value;
        reorder_q[tail_q] <= ALU_reorder;
        jump_q[tail_q]    <= res_jump;
        target_q[tail_q]  <= res_target;
      end
    end
  end

  // Stall two entries early: one dispatch may already be in flight from the RS output register.
  assign alu_stall    = (count_q >= CntStall);
  assign cdb_req      = (count_q != '0);
  assign cdb_value    = value_q[head_q];
  assign cdb_reorder  = reorder_q[head_q];
  assign cdb_jump     = jump_q[head_q];
  assign cdb_target   = target_q[head_q];
  assign alu_overflow = overflow_q;

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: expected head entries are queued when a dispatch is driven and
// compared when the CDB grant pops them.
module tb_alu_exec;

  localparam logic [4:0] OP_JALR  = 5'd4;
  localparam logic [4:0] OP_BEQ   = 5'd5;
  localparam logic [4:0] OP_BLT   = 5'd7;
  localparam logic [4:0] OP_BGEU  = 5'd10;
  localparam logic [4:0] OP_ADDI  = 5'd11;
  localparam logic [4:0] OP_SRAI  = 5'd19;
  localparam logic [4:0] OP_ADD   = 5'd20;
  localparam logic [4:0] OP_SUB   = 5'd21;
  localparam logic [4:0] OP_SLT   = 5'd23;
  localparam logic [4:0] OP_SLTU  = 5'd24;
  localparam logic [4:0] OP_JAL   = 5'd3;
  localparam logic [4:0] OP_LUI   = 5'd1;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        jump_rst;
  logic        RS_send_ALU;
  logic [4:0]  ALU_op;
  logic [31:0] ALU_Vj, ALU_Vk, ALU_imm, ALU_curPC;
  logic [3:0]  ALU_reorder;
  logic        alu_stall;
  logic        cdb_req;
  logic [31:0] cdb_value;
  logic [3:0]  cdb_reorder;
  logic        cdb_jump;
  logic [31:0] cdb_target;
  logic        cdb_grant;
  logic        alu_overflow;

  alu_exec #(
    .FIFO_DEPTH     (4),
    .FIFO_DEPTH_LOG (2),
    .OP_SIZE_LOG    (5),
    .ROB_SIZE_LOG   (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .jump_rst     (jump_rst),
    .RS_send_ALU  (RS_send_ALU),
    .ALU_op       (ALU_op),
    .ALU_Vj       (ALU_Vj),
    .ALU_Vk       (ALU_Vk),
    .ALU_imm      (ALU_imm),
    .ALU_curPC    (ALU_curPC),
    .ALU_reorder  (ALU_reorder),
    .alu_stall    (alu_stall),
    .cdb_req      (cdb_req),
    .cdb_value    (cdb_value),
    .cdb_reorder  (cdb_reorder),
    .cdb_jump     (cdb_jump),
    .cdb_target   (cdb_target),
    .cdb_grant    (cdb_grant),
    .alu_overflow (alu_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] value;
    logic [3:0]  tag;
    logic        jump;
    logic [31:0] target;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle of stimulus. push_exp / pop_exp say whether the bench expects the DUT to accept the
  // dispatch / the grant; a popped head is compared against the scoreboard front before the edge.
  task automatic drive(input bit send, input bit push_exp, input bit grant, input bit pop_exp,
                       input logic [4:0] op, input logic [31:0] vj, input logic [31:0] vk,
                       input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] tag,
                       input logic [31:0] ev, input logic ej, input logic [31:0] et);
    exp_t e;
    if (pop_exp) begin
      chk("head_req", {31'b0, cdb_req}, 32'd1);
      if (sb.size() == 0) begin
        chk("scoreboard_nonempty", 32'd0, 32'd1);
      end else begin
        e = sb[0];
        chk("head_value", cdb_value, e.value);
        chk("head_tag", {28'b0, cdb_reorder}, {28'b0, e.tag});
        chk("head_jump", {31'b0, cdb_jump}, {31'b0, e.jump});
        chk("head_target", cdb_target, e.target);
      end
    end
    RS_send_ALU = send;
    ALU_op      = op;
    ALU_Vj      = vj;
    ALU_Vk      = vk;
    ALU_imm     = imm;
    ALU_curPC   = pc;
    ALU_reorder = tag;
    cdb_grant   = grant;
    @(posedge clk);
    #1;
    RS_send_ALU = 1'b0;
    cdb_grant   = 1'b0;
    if (pop_exp && sb.size() != 0) void'(sb.pop_front());
    if (push_exp) begin
      e.value  = ev;
      e.tag    = tag;
      e.jump   = ej;
      e.target = et;
      sb.push_back(e);
    end
  endtask

  task automatic send_op(input logic [4:0] op, input logic [31:0] vj, input logic [31:0] vk,
                         input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] tag,
                         input logic [31:0] ev, input logic ej, input logic [31:0] et);
    drive(1'b1, 1'b1, 1'b0, 1'b0, op, vj, vk, imm, pc, tag, ev, ej, et);
  endtask

  task automatic grant_pop();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0, 32'd0, 1'b0, 32'd0);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; jump_rst = 1'b0; RS_send_ALU = 1'b0; cdb_grant = 1'b0;
    ALU_op = '0; ALU_Vj = '0; ALU_Vk = '0; ALU_imm = '0; ALU_curPC = '0; ALU_reorder = '0;
    #12;
    chk("rst_req", {31'b0, cdb_req}, 32'd0);
    chk("rst_stall", {31'b0, alu_stall}, 32'd0);
    chk("rst_overflow", {31'b0, alu_overflow}, 32'd0);
    chk("rst_value", cdb_value, 32'd0);
    chk("rst_target", cdb_target, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // ADD wraps; head holds until granted.
    send_op(OP_ADD, 32'd5, 32'hFFFF_FFFE, 32'd0, 32'd0, 4'd1, 32'd3, 1'b0, 32'd0);
    chk("add_req", {31'b0, cdb_req}, 32'd1);
    chk("add_value", cdb_value, 32'd3);
    chk("add_jump", {31'b0, cdb_jump}, 32'd0);
    idle();
    chk("add_hold_req", {31'b0, cdb_req}, 32'd1);
    chk("add_hold_value", cdb_value, 32'd3);
    grant_pop();
    chk("add_popped_req", {31'b0, cdb_req}, 32'd0);

    // Shifts and compares.
    send_op(OP_SRAI, 32'h8000_0000, 32'd0, 32'h404, 32'd0, 4'd2, 32'hF800_0000, 1'b0, 32'd0);
    send_op(OP_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 4'd3, 32'd1, 1'b0, 32'd0);
    send_op(OP_SLT, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 4'd4, 32'd0, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) grant_pop();

    // Branches and JALR; four entries fill the FIFO.
    send_op(OP_BLT, 32'hFFFF_FFFF, 32'd0, 32'h20, 32'h100, 4'd5, 32'd0, 1'b1, 32'h120);
    send_op(OP_BGEU, 32'hFFFF_FFFF, 32'd0, 32'h20, 32'h100, 4'd6, 32'd0, 1'b1, 32'h120);
    send_op(OP_BEQ, 32'd7, 32'd8, 32'h20, 32'h100, 4'd7, 32'd0, 1'b0, 32'h104);
    send_op(OP_JALR, 32'h1001, 32'd0, 32'd2, 32'h40, 4'd8, 32'h44, 1'b1, 32'h1002);
    for (int i = 0; i < 4; i++) grant_pop();

    // JAL, LUI, SUB.
    send_op(OP_JAL, 32'd0, 32'd0, 32'h10, 32'h200, 4'd9, 32'h204, 1'b1, 32'h210);
    send_op(OP_LUI, 32'd0, 32'd0, 32'h1234_5000, 32'd0, 4'd10, 32'h1234_5000, 1'b0, 32'd0);
    send_op(OP_SUB, 32'd3, 32'd5, 32'd0, 32'd0, 4'd11, 32'hFFFF_FFFE, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) grant_pop();

    // Fill, stall threshold, push+pop while full, then a dropped push.
    for (int i = 0; i < 4; i++) begin
      send_op(OP_ADDI, 32'(i * 16), 32'd0, 32'(i), 32'd0, 4'(8 + i), 32'(i * 17), 1'b0, 32'd0);
      if (i == 0) chk("stall_at_1", {31'b0, alu_stall}, 32'd0);
      if (i == 1) chk("stall_at_2", {31'b0, alu_stall}, 32'd1);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1, OP_ADDI, 32'd100, 32'd0, 32'd1, 32'd0, 4'd12,
          32'd101, 1'b0, 32'd0);
    chk("full_pushpop_no_overflow", {31'b0, alu_overflow}, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, OP_ADDI, 32'd200, 32'd0, 32'd1, 32'd0, 4'd13,
          32'd0, 1'b0, 32'd0);
    chk("drop_overflow", {31'b0, alu_overflow}, 32'd1);
    for (int i = 0; i < 4; i++) grant_pop();
    chk("drained_req", {31'b0, cdb_req}, 32'd0);
    chk("overflow_sticky", {31'b0, alu_overflow}, 32'd1);

    // Flush with a same-edge dispatch and grant.
    for (int i = 0; i < 3; i++)
      send_op(OP_ADDI, 32'd0, 32'd0, 32'(i), 32'd0, 4'(1 + i), 32'(i), 1'b0, 32'd0);
    jump_rst = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 1'b0, OP_ADD, 32'd1, 32'd1, 32'd0, 32'd0, 4'd9,
          32'd0, 1'b0, 32'd0);
    jump_rst = 1'b0;
    sb.delete();
    chk("flush_req", {31'b0, cdb_req}, 32'd0);
    chk("flush_stall", {31'b0, alu_stall}, 32'd0);
    send_op(OP_ADD, 32'd20, 32'd22, 32'd0, 32'd0, 4'd5, 32'd42, 1'b0, 32'd0);
    chk("post_flush_stall", {31'b0, alu_stall}, 32'd0);
    grant_pop();
    chk("post_flush_req", {31'b0, cdb_req}, 32'd0);

    // rdy low freezes dispatch and grant.
    send_op(OP_ADD, 32'd1, 32'd1, 32'd0, 32'd0, 4'd6, 32'd2, 1'b0, 32'd0);
    rdy = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 1'b0, OP_ADD, 32'd9, 32'd9, 32'd0, 32'd0, 4'd7,
          32'd0, 1'b0, 32'd0);
    rdy = 1'b1;
    chk("rdy_low_req", {31'b0, cdb_req}, 32'd1);
    chk("rdy_low_stall", {31'b0, alu_stall}, 32'd0);
    grant_pop();
    chk("rdy_low_drained", {31'b0, cdb_req}, 32'd0);

    // Asynchronous reset mid-operation.
    send_op(OP_ADD, 32'd4, 32'd4, 32'd0, 32'd0, 4'd3, 32'd8, 1'b0, 32'd0);
    send_op(OP_ADD, 32'd4, 32'd5, 32'd0, 32'd0, 4'd4, 32'd9, 1'b0, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_req", {31'b0, cdb_req}, 32'd0);
    chk("async_rst_stall", {31'b0, alu_stall}, 32'd0);
    chk("async_rst_overflow", {31'b0, alu_overflow}, 32'd0);
    chk("async_rst_value", cdb_value, 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
